// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// No logic; state encoding and default start-timeout only.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GUARD     = 2'd3
    } arb_state_t;

    localparam int START_TIMEOUT_DEFAULT = 16;
    localparam int GRANT_W               = 3;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first asserted request after last_grant, wrapping at NUM_REQ.
// Combinational, zero latency; no backpressure.
module rr_priority_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               any
);
    localparam int PW = GRANT_W + 1;

    logic [PW-1:0]        shamt;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PW-1:0]        pos;

    // Rotate so that bit 0 of rot is the requester right after last_grant.
    assign shamt = {1'b0, last_grant} + PW'(1);
    assign dbl   = {req, req} >> shamt;
    assign rot   = dbl[NUM_REQ-1:0];

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                pos = {1'b0, last_grant} + PW'(i) + PW'(1);
                if (pos >= PW'(NUM_REQ)) begin
                    pos = pos - PW'(NUM_REQ);
                end
                grant_idx = pos[GRANT_W-1:0];
                grant     = NUM_REQ'(1) << grant_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter handing one byte at a time to a single UART transmitter, one frame per grant.
// Latency: ready/enable/data appear the cycle after a grant decision in IDLE; requesters wait while the transmitter is busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic                   i_CLK,
    input  logic                   i_RESET,
    input  logic [NUM_REQ-1:0]     i_REQ_VALID,
    input  logic [8*NUM_REQ-1:0]   i_REQ_DATA,
    output logic [NUM_REQ-1:0]     o_REQ_READY,
    output logic                   o_TX_ENABLE,
    output logic [7:0]             o_TX_DATA,
    input  logic                   i_TX_BUSY,
    output logic [GRANT_W-1:0]     o_GRANT_ID,
    output logic                   o_ACTIVE,
    output logic                   o_ERR_TIMEOUT
);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arb_state_t         state;
    logic [GRANT_W-1:0] last_grant;
    logic [CNT_W-1:0]   tmo_cnt;

    logic [NUM_REQ-1:0] pick_grant;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_any;
    logic [7:0]         pick_byte;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (i_REQ_VALID),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        pick_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) begin
                pick_byte = i_REQ_DATA[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state         <= ST_IDLE;
            last_grant    <= GRANT_W'(NUM_REQ - 1);
            tmo_cnt       <= '0;
            o_REQ_READY   <= '0;
            o_TX_ENABLE   <= 1'b0;
            o_TX_DATA     <= '0;
            o_GRANT_ID    <= '0;
            o_ACTIVE      <= 1'b0;
            o_ERR_TIMEOUT <= 1'b0;
        end else begin
            o_REQ_READY   <= '0;
            o_ERR_TIMEOUT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Byte is captured on the same edge the ready pulse is launched, so it is held until handshake.
                    if (pick_any && !i_TX_BUSY) begin
                        state       <= ST_LAUNCH;
                        o_ACTIVE    <= 1'b1;
                        o_TX_ENABLE <= 1'b1;
                        o_TX_DATA   <= pick_byte;
                        o_REQ_READY <= pick_grant;
                        o_GRANT_ID  <= pick_idx;
                        last_grant  <= pick_idx;
                        tmo_cnt     <= '0;
                    end
                end
                ST_LAUNCH: begin
                    if (i_TX_BUSY) begin
                        state       <= ST_WAIT_DONE;
                        o_TX_ENABLE <= 1'b0;
                    end else if (tmo_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        state         <= ST_IDLE;
                        o_TX_ENABLE   <= 1'b0;
                        o_ACTIVE      <= 1'b0;
                        o_ERR_TIMEOUT <= 1'b1;
                    end else if (tmo_cnt != CNT_W'(START_TIMEOUT)) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_TX_BUSY) begin
                        state <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    state    <= ST_IDLE;
                    o_ACTIVE <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    o_TX_ENABLE <= 1'b0;
                    o_ACTIVE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a transmitter model drive the DUT,
// a monitor checks grants and frames against a round-robin scoreboard.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk;
    logic           i_RESET;
    logic [N-1:0]   i_REQ_VALID;
    logic [8*N-1:0] i_REQ_DATA;
    logic [N-1:0]   o_REQ_READY;
    logic           o_TX_ENABLE;
    logic [7:0]     o_TX_DATA;
    logic           i_TX_BUSY;
    logic [2:0]     o_GRANT_ID;
    logic           o_ACTIVE;
    logic           o_ERR_TIMEOUT;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TMO)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (i_RESET),
        .i_REQ_VALID   (i_REQ_VALID),
        .i_REQ_DATA    (i_REQ_DATA),
        .o_REQ_READY   (o_REQ_READY),
        .o_TX_ENABLE   (o_TX_ENABLE),
        .o_TX_DATA     (o_TX_DATA),
        .i_TX_BUSY     (i_TX_BUSY),
        .o_GRANT_ID    (o_GRANT_ID),
        .o_ACTIVE      (o_ACTIVE),
        .o_ERR_TIMEOUT (o_ERR_TIMEOUT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       tmo;
        logic [2:0] id;
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rq[N][$];
    int         gseq[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   force_busy = 0;
    bit   tx_dead    = 0;
    bit   chk_gap    = 0;
    bit   in_frame   = 0;
    int   model_last = N - 1;
    int   fall_cyc   = -1;
    int   cyc        = 0;
    int   post_rst_first = -1;
    int   n_ready  = 0;
    int   n_frames = 0;
    int   n_tmo    = 0;
    logic [7:0] frame_byte = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Reference arbitration: scan requesters in order after the previous winner.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    // Requesters and transmitter model, driven mid-cycle.
    initial begin : env
        logic [N-1:0]   pend;
        logic [N-1:0]   vld;
        logic [8*N-1:0] dat;
        int tx_rem, wcnt, tdelay;
        pend = '0; tx_rem = 0; wcnt = 0; tdelay = 0;
        i_REQ_VALID = '0;
        i_REQ_DATA  = '0;
        i_TX_BUSY   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < N; k++) begin
                if (pend[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            pend = o_REQ_READY & i_REQ_VALID;
            vld = '0;
            dat = '0;
            for (int k = 0; k < N; k++) begin
                if (rq[k].size() > 0) begin
                    vld[k]        = 1'b1;
                    dat[8*k +: 8] = rq[k][0];
                end
            end
            i_REQ_VALID = vld;
            i_REQ_DATA  = dat;
            if (i_RESET) begin
                tx_rem = 0;
                wcnt   = 0;
            end else if (tx_rem > 0) begin
                tx_rem--;
            end else if (o_TX_ENABLE && !tx_dead && !force_busy) begin
                if (wcnt >= tdelay) begin
                    tx_rem = $urandom_range(6, 2);
                    wcnt   = 0;
                    tdelay = $urandom_range(2, 0);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            i_TX_BUSY = force_busy || (tx_rem > 0);
        end
    end

    initial begin : mon
        int k;
        exp_t e;
        logic [N-1:0] ready_prev;
        logic err_prev;
        int en_run, last_run;
        ready_prev = '0; err_prev = 1'b0; en_run = 0; last_run = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (i_RESET) begin
                chk("rst_ready", 32'(o_REQ_READY), 0);
                chk("rst_enable", 32'(o_TX_ENABLE), 0);
                chk("rst_data", 32'(o_TX_DATA), 0);
                chk("rst_grant_id", 32'(o_GRANT_ID), 0);
                chk("rst_active", 32'(o_ACTIVE), 0);
                chk("rst_err", 32'(o_ERR_TIMEOUT), 0);
                model_last = N - 1;
                exp_q.delete();
                in_frame = 0; en_run = 0; last_run = 0; fall_cyc = -1;
                post_rst_first = -1; ready_prev = '0; err_prev = 1'b0;
                continue;
            end
            if (o_TX_ENABLE) begin
                en_run++;
            end else begin
                if (en_run != 0) last_run = en_run;
                en_run = 0;
            end
            if (o_REQ_READY != '0) begin
                k = rr_pick(i_REQ_VALID, model_last);
                chk("grant_onehot", 32'(o_REQ_READY), (k < 0) ? 0 : (32'd1 << k));
                chk("busy_low_at_grant", 32'(i_TX_BUSY), 0);
                chk("ready_single_cycle", 32'(ready_prev), 0);
                chk("active_at_grant", 32'(o_ACTIVE), 1);
                if (k >= 0) begin
                    e.tmo = tx_dead;
                    e.id  = 3'(k);
                    e.dat = i_REQ_DATA[8*k +: 8];
                    exp_q.push_back(e);
                    model_last = k;
                    gseq.push_back(k);
                    if (post_rst_first < 0) post_rst_first = k;
                end
                if (fall_cyc >= 0) begin
                    chk("guard_gap_min", 32'(cyc - fall_cyc >= 2), 1);
                    if (chk_gap) chk("guard_gap_b2b", 32'(cyc - fall_cyc), 2);
                end
                fall_cyc = -1;
                n_ready++;
            end
            if (!force_busy && i_TX_BUSY && !in_frame) begin
                in_frame = 1;
                n_frames++;
                frame_byte = o_TX_DATA;
                chk("frame_expected", 32'(exp_q.size()), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("frame_not_timeout", 32'(e.tmo), 0);
                    chk("frame_byte", 32'(o_TX_DATA), 32'(e.dat));
                    chk("frame_grant_id", 32'(o_GRANT_ID), 32'(e.id));
                end
            end else if (in_frame && !i_TX_BUSY) begin
                in_frame = 0;
                fall_cyc = cyc;
                chk("data_stable", 32'(o_TX_DATA), 32'(frame_byte));
            end
            if (in_frame) chk("enable_low_in_frame", 32'(o_TX_ENABLE), 0);
            if (o_ERR_TIMEOUT) begin
                n_tmo++;
                chk("err_single_cycle", 32'(err_prev), 0);
                chk("timeout_enable_len", 32'(last_run), TMO);
                chk("timeout_expected", 32'(exp_q.size()), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("timeout_kind", 32'(e.tmo), 1);
                end
            end
            if (o_TX_ENABLE) chk("active_with_enable", 32'(o_ACTIVE), 1);
            ready_prev = o_REQ_READY;
            err_prev   = o_ERR_TIMEOUT;
        end
    end

    function automatic bit idle_now();
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() != 0) return 0;
        end
        return (exp_q.size() == 0) && !i_TX_BUSY && !o_ACTIVE && !in_frame;
    endfunction

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 4000 && quiet < 3; i++) begin
            @(negedge clk);
            if (idle_now()) quiet++;
            else quiet = 0;
        end
        chk("drained_to_idle", 32'(quiet >= 3), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_RESET = 1'b1;
        @(negedge clk);
        i_RESET = 1'b0;
    endtask

    initial begin : main
        int fr0, t0, r0, k, i;
        int exp_order[5];
        i_RESET = 1'b1;
        repeat (3) @(negedge clk);
        i_RESET = 1'b0;

        // Single requester, single byte.
        fr0 = n_frames;
        rq[0].push_back(8'h3E);
        wait_idle();
        chk("single_frame_count", 32'(n_frames - fr0), 1);
        chk("single_frame_byte", 32'(frame_byte), 32'h3E);

        // All four held valid: order must rotate starting at 0.
        do_reset();
        gseq.delete();
        fr0 = n_frames;
        for (int j = 0; j < N; j++) rq[j].push_back(8'(8'h10 + j));
        rq[0].push_back(8'h14);
        wait_idle();
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_grant_count", 32'(gseq.size()), 5);
        for (int j = 0; j < 5 && j < gseq.size(); j++) chk("rr_order", 32'(gseq[j]), 32'(exp_order[j]));
        chk("rr_frame_count", 32'(n_frames - fr0), 5);

        // Transmitter never responds: start timeout.
        tx_dead = 1;
        t0 = n_tmo; fr0 = n_frames;
        rq[1].push_back(8'hA5);
        wait_idle();
        tx_dead = 0;
        chk("timeout_pulses", 32'(n_tmo - t0), 1);
        chk("timeout_no_frame", 32'(n_frames - fr0), 0);

        // Lone requester 2 back-to-back.
        fall_cyc = -1;
        chk_gap = 1;
        gseq.delete();
        for (int j = 0; j < 3; j++) rq[2].push_back(8'(8'hC0 + j));
        wait_idle();
        chk_gap = 0;
        chk("lone_grant_count", 32'(gseq.size()), 3);
        for (int j = 0; j < gseq.size(); j++) chk("lone_grant_id", 32'(gseq[j]), 2);

        // Transmitter busy while idle holds off all grants.
        force_busy = 1;
        r0 = n_ready;
        rq[0].push_back(8'h55);
        rq[3].push_back(8'hAA);
        repeat (20) @(negedge clk);
        chk("no_grant_while_busy", 32'(n_ready - r0), 0);
        force_busy = 0;
        wait_idle();
        chk("grants_after_busy", 32'(n_ready - r0), 2);

        // Random traffic.
        for (int j = 0; j < 60; j++) begin
            repeat ($urandom_range(4, 0)) @(negedge clk);
            k = $urandom_range(N - 1, 0);
            if (rq[k].size() < 4) rq[k].push_back(8'($urandom));
        end
        wait_idle();
        for (int j = 0; j < 2; j++) begin
            tx_dead = 1;
            t0 = n_tmo;
            rq[$urandom_range(N - 1, 0)].push_back(8'($urandom));
            wait_idle();
            tx_dead = 0;
            chk("rand_timeout_pulse", 32'(n_tmo - t0), 1);
        end

        // Reset in the middle of a frame.
        for (int j = 0; j < N; j++) begin
            rq[j].push_back(8'($urandom));
            rq[j].push_back(8'($urandom));
        end
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_frame && i_TX_BUSY) break;
        end
        chk("reached_wait_done", 32'(in_frame), 1);
        i_RESET = 1'b1;
        @(negedge clk);
        i_RESET = 1'b0;
        for (i = 0; i < 100 && post_rst_first < 0; i++) @(negedge clk);
        chk("first_grant_after_reset", 32'(post_rst_first), 0);
        wait_idle();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #800000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
